// File: rtl/spu_hazard_ctrl_pkg.sv
// Shared types and constants for the SPU front-end hazard controller.
package spu_hazard_ctrl_pkg;

  localparam int unsigned NREGS          = 128;
  localparam int unsigned REG_W          = 7;
  localparam int unsigned LAT_W          = 3;
  localparam int unsigned PERF_W_DEFAULT = 32;
  localparam int unsigned NSRC           = 3;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

  // Back-to-back dependent stall cycles per execution unit (0 = fully forwarded)
  localparam lat_t LAT_FX2  = LAT_W'(1);
  localparam lat_t LAT_BYTE = LAT_W'(3);
  localparam lat_t LAT_FX3  = LAT_W'(3);
  localparam lat_t LAT_SFP  = LAT_W'(5);
  localparam lat_t LAT_LS   = LAT_W'(5);
  localparam lat_t LAT_PERM = LAT_W'(3);
  localparam lat_t LAT_BR   = LAT_W'(0);

endpackage

// File: rtl/spu_hazard_ctrl_if.sv
// Decode-stage / hazard-controller handshake: ID operands in, pipeline enables out.
interface spu_hazard_ctrl_if #(
  parameter int unsigned PERF_W = spu_hazard_ctrl_pkg::PERF_W_DEFAULT
);

  logic                            id_valid;
  spu_hazard_ctrl_pkg::reg_idx_t   id_ra;
  spu_hazard_ctrl_pkg::reg_idx_t   id_rb;
  spu_hazard_ctrl_pkg::reg_idx_t   id_rc;
  logic [2:0]                      id_src_used;
  spu_hazard_ctrl_pkg::reg_idx_t   id_rt;
  logic                            id_wr_rt;
  spu_hazard_ctrl_pkg::lat_t       id_lat;
  logic                            ex_flush;

  logic                            pc_en;
  logic                            if_id_en;
  logic                            if_id_flush;
  logic                            id_ex_flush;
  logic                            id_issue;
  logic [PERF_W-1:0]               stall_cnt;
  logic [PERF_W-1:0]               flush_cnt;

  // Pipeline side: presents the decoded instruction, consumes enables
  modport master (
    output id_valid, id_ra, id_rb, id_rc, id_src_used, id_rt, id_wr_rt, id_lat, ex_flush,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, id_issue, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_ra, id_rb, id_rc, id_src_used, id_rt, id_wr_rt, id_lat, ex_flush,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, id_issue, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/spu_hazard_ctrl_sb_counter.sv
// One scoreboard entry: result countdown for a single architectural register.
module spu_hazard_ctrl_sb_counter
  import spu_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  lat_t load_val,
  output logic busy,
  output lat_t count
);

  // A new issue to this register replaces the running countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - LAT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/spu_hazard_ctrl.sv
// Scoreboard hazard detection and PC/IF-ID/ID-EX stall and flush control.
module spu_hazard_ctrl
  import spu_hazard_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  spu_hazard_ctrl_if.slave     bus
);

  logic [NREGS-1:0] sb_busy;
  lat_t             sb_count [NREGS];
  logic [NREGS-1:0] sb_load;
  logic [NSRC-1:0]  src_busy_c;
  logic             raw_c;
  logic             waw_c;
  logic             stall_c;
  logic             issue_c;
  logic             pc_en_c;
  logic             if_id_en_c;
  logic             if_id_flush_c;
  logic             id_ex_flush_c;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Per-register countdowns
  for (genvar g = 0; g < int'(NREGS); g++) begin : g_sb
    spu_hazard_ctrl_sb_counter u_sb (
      .clk      (clk),
      .reset    (reset),
      .load     (sb_load[g]),
      .load_val (bus.id_lat),
      .busy     (sb_busy[g]),
      .count    (sb_count[g])
    );
  end

  // RAW on any used source still counting; WAW if the older write would land after ours
  always_comb begin
    src_busy_c    = '0;
    src_busy_c[0] = sb_busy[bus.id_ra];
    src_busy_c[1] = sb_busy[bus.id_rb];
    src_busy_c[2] = sb_busy[bus.id_rc];
    raw_c   = bus.id_valid && (|(src_busy_c & bus.id_src_used));
    waw_c   = bus.id_valid && bus.id_wr_rt && (sb_count[bus.id_rt] > bus.id_lat);
    stall_c = raw_c || waw_c;
  end

  // Pipeline control with priority reset > ex_flush > stall > issue
  always_comb begin
    pc_en_c       = 1'b1;
    if_id_en_c    = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    issue_c       = 1'b0;
    if (reset) begin
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (bus.ex_flush) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (stall_c) begin
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      id_ex_flush_c = 1'b1;
    end else begin
      issue_c       = bus.id_valid;
      id_ex_flush_c = !bus.id_valid;
    end
  end

  // Arm the destination countdown only for issued writers that need interlocking
  always_comb begin
    sb_load = '0;
    if (issue_c && bus.id_wr_rt && (bus.id_lat != '0)) begin
      sb_load[bus.id_rt] = 1'b1;
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.ex_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
      if (!bus.ex_flush && stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.if_id_en    = if_id_en_c;
  assign bus.if_id_flush = if_id_flush_c;
  assign bus.id_ex_flush = id_ex_flush_c;
  assign bus.id_issue    = issue_c;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_spu_hazard_ctrl.sv
// Directed vector bench for spu_hazard_ctrl; a narrow-counter copy checks saturation.
module tb_spu_hazard_ctrl;
  import spu_hazard_ctrl_pkg::*;

  localparam int unsigned SAT_W = 2;
  localparam int SAT_MAX = 3;

  // expected {pc_en, if_id_en, if_id_flush, id_ex_flush, id_issue}
  localparam logic [4:0] ISSUE  = 5'b11001;
  localparam logic [4:0] BUBBLE = 5'b11010;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] FLUSH  = 5'b11110;
  localparam logic [4:0] RST    = 5'b00110;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       valid;
    reg_idx_t   ra;
    reg_idx_t   rb;
    reg_idx_t   rc;
    logic [2:0] used;
    reg_idx_t   rt;
    logic       wr;
    lat_t       lat;
    logic [4:0] exp_ctl;
    int         exp_sc;   // -1: counters not yet defined
    int         exp_fc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  spu_hazard_ctrl_if #(.PERF_W(PERF_W_DEFAULT)) bus ();
  spu_hazard_ctrl_if #(.PERF_W(SAT_W))          sat_bus ();

  spu_hazard_ctrl #(.PERF_W(PERF_W_DEFAULT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  spu_hazard_ctrl #(.PERF_W(SAT_W)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus)
  );

  assign sat_bus.id_valid    = bus.id_valid;
  assign sat_bus.id_ra       = bus.id_ra;
  assign sat_bus.id_rb       = bus.id_rb;
  assign sat_bus.id_rc       = bus.id_rc;
  assign sat_bus.id_src_used = bus.id_src_used;
  assign sat_bus.id_rt       = bus.id_rt;
  assign sat_bus.id_wr_rt    = bus.id_wr_rt;
  assign sat_bus.id_lat      = bus.id_lat;
  assign sat_bus.ex_flush    = bus.ex_flush;

  function automatic vec_t mk(input logic rst, input logic flush, input logic valid,
                              input int ra, input int rb, input int rc, input logic [2:0] used,
                              input int rt, input logic wr, input int lat,
                              input logic [4:0] exp_ctl, input int sc, input int fc);
    vec_t v;
    v.rst = rst; v.flush = flush; v.valid = valid;
    v.ra = REG_W'(ra); v.rb = REG_W'(rb); v.rc = REG_W'(rc); v.used = used;
    v.rt = REG_W'(rt); v.wr = wr; v.lat = LAT_W'(lat);
    v.exp_ctl = exp_ctl; v.exp_sc = sc; v.exp_fc = fc;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x > SAT_MAX) ? SAT_MAX : x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset           = v.rst;
    bus.ex_flush    = v.flush;
    bus.id_valid    = v.valid;
    bus.id_ra       = v.ra;
    bus.id_rb       = v.rb;
    bus.id_rc       = v.rc;
    bus.id_src_used = v.used;
    bus.id_rt       = v.rt;
    bus.id_wr_rt    = v.wr;
    bus.id_lat      = v.lat;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("ctl", idx, 32'({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.id_issue}),
        32'(v.exp_ctl));
    chk("ctl_sat", idx, 32'({sat_bus.pc_en, sat_bus.if_id_en, sat_bus.if_id_flush,
                             sat_bus.id_ex_flush, sat_bus.id_issue}), 32'(v.exp_ctl));
    if (v.exp_sc >= 0) begin
      chk("stall_cnt", idx, bus.stall_cnt, 32'(v.exp_sc));
      chk("flush_cnt", idx, bus.flush_cnt, 32'(v.exp_fc));
      chk("stall_cnt_sat", idx, 32'(sat_bus.stall_cnt), 32'(sat(v.exp_sc)));
      chk("flush_cnt_sat", idx, 32'(sat_bus.flush_cnt), 32'(sat(v.exp_fc)));
    end
  endtask

  initial begin
    // reset held two cycles
    vecs.push_back(mk(1,0,1, 1,0,0,3'b001, 2,1,0, RST, -1,-1));
    vecs.push_back(mk(1,0,1, 1,0,0,3'b001, 2,1,0, RST, 0,0));
    // independent instruction right after reset
    vecs.push_back(mk(0,0,1, 1,0,0,3'b001, 2,1,0, ISSUE, 0,0));
    // RAW: r5 with lat 5, reader stalls five cycles then issues
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 5,1,int'(LAT_SFP), ISSUE, 0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, STALL, i,0));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, ISSUE, 5,0));
    // fully forwarded producer: dependent issues back to back
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 7,1,int'(LAT_BR), ISSUE, 5,0));
    vecs.push_back(mk(0,0,1, 7,7,0,3'b011, 12,1,0, ISSUE, 5,0));
    // WAW: r9 lat 5, then a lat-1 writer of r9 waits until sb[r9] <= 1
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 9,1,int'(LAT_LS), ISSUE, 5,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 9,1,int'(LAT_FX2), STALL, 5+i,0));
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 9,1,int'(LAT_FX2), ISSUE, 9,0));
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 9,1,int'(LAT_SFP), ISSUE, 9,0));
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 9,1,int'(LAT_SFP), ISSUE, 9,0));
    // flush over a stall, then reset mid-stall with sb[r5]=3
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 5,1,int'(LAT_SFP), ISSUE, 9,0));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, STALL, 9,0));
    vecs.push_back(mk(0,1,1, 5,0,0,3'b001, 10,1,0, FLUSH, 10,0));
    vecs.push_back(mk(1,0,1, 5,0,0,3'b001, 10,1,0, RST, 10,1));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, ISSUE, 0,0));
    // source == rt sees the old (idle) entry; flushes keep r5 counting down
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 5,1,int'(LAT_BYTE), ISSUE, 0,0));
    vecs.push_back(mk(0,1,1, 5,0,0,3'b001, 10,1,0, FLUSH, 0,0));
    vecs.push_back(mk(0,1,1, 5,0,0,3'b001, 10,1,0, FLUSH, 0,1));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, STALL, 0,2));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 10,1,0, ISSUE, 1,2));
    // source == rt on a busy entry stalls on the old value
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 20,1,int'(LAT_PERM), ISSUE, 1,2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1, 20,0,0,3'b001, 20,1,int'(LAT_PERM), STALL, 1+i,2));
    vecs.push_back(mk(0,0,1, 20,0,0,3'b001, 20,1,int'(LAT_PERM), ISSUE, 4,2));
    // rc port and source-use gating
    vecs.push_back(mk(0,0,1, 0,0,0,3'b000, 30,1,int'(LAT_FX3), ISSUE, 4,2));
    vecs.push_back(mk(0,0,1, 0,0,30,3'b100, 11,1,0, STALL, 4,2));
    vecs.push_back(mk(0,0,1, 30,30,1,3'b100, 11,1,0, ISSUE, 5,2));
    // no valid instruction: bubble, never a stall
    vecs.push_back(mk(0,0,0, 30,0,0,3'b001, 30,1,0, BUBBLE, 5,2));
    vecs.push_back(mk(0,1,0, 30,0,0,3'b001, 30,1,0, FLUSH, 5,2));
    vecs.push_back(mk(0,0,0, 30,0,0,3'b001, 30,1,0, BUBBLE, 5,3));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
      @(negedge clk);
    end

    // five more flushes: wide counter reaches 8, narrow one holds all-ones
    for (int i = 0; i < 5; i++) begin
      bus.ex_flush = 1'b1;
      bus.id_valid = 1'b0;
      @(negedge clk);
    end
    bus.ex_flush = 1'b0;
    #1;
    chk("flush_cnt_seq", 100, bus.flush_cnt, 32'd8);
    chk("flush_cnt_sat_seq", 100, 32'(sat_bus.flush_cnt), 32'(SAT_MAX));
    chk("stall_cnt_seq", 100, bus.stall_cnt, 32'd5);
    chk("stall_cnt_sat_seq", 100, 32'(sat_bus.stall_cnt), 32'(SAT_MAX));

    // reset clears counters on the next edge
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("flush_cnt_rst", 101, bus.flush_cnt, 32'd0);
    chk("stall_cnt_rst", 101, bus.stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
